// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: walks a combinational ROM, hands words to decode
// over a valid/ready handshake, and supports redirect, halt/resume and address faults.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ROM_Addr,
  input  logic [31:0] ROM_Inst,
  output logic        IF_Valid,
  input  logic        ID_Ready,
  output logic [31:0] IF_Inst,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  input  logic        Redir_Valid,
  input  logic [31:0] Redir_PC,
  input  logic        Halt_Req,
  input  logic        Resume,
  output logic        Addr_Err,
  output logic [31:0] Fetch_Cnt
);

  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;

  logic transfer;
  logic can_adv;
  logic redir_bad;
  logic pc_oob;

  assign ROM_Addr  = fetch_pc;
  assign transfer  = IF_Valid & ID_Ready;
  assign can_adv   = ~IF_Valid | ID_Ready;
  assign redir_bad = (Redir_PC[1:0] != 2'b00) || (Redir_PC >= ROM_BYTES);
  assign pc_oob    = (fetch_pc >= ROM_BYTES);

  // Priority in RUN: redirect, then halt, then normal fetch (which may fault).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      fetch_pc  <= RESET_PC;
      IF_Valid  <= 1'b0;
      IF_Inst   <= 32'h0;
      IF_PC     <= 32'h0;
      IF_PC4    <= 32'h0;
      Addr_Err  <= 1'b0;
      Fetch_Cnt <= 32'h0;
    end else begin
      if (transfer) Fetch_Cnt <= Fetch_Cnt + 32'd1;

      case (state)
        S_WAIT: state <= S_RUN;

        S_RUN: begin
          if (Redir_Valid) begin
            IF_Valid <= 1'b0;
            if (redir_bad) begin
              Addr_Err <= 1'b1;
              state    <= S_HALT;
            end else begin
              fetch_pc <= Redir_PC;
            end
          end else if (Halt_Req) begin
            state <= S_HALT;
            if (transfer) IF_Valid <= 1'b0;
          end else if (can_adv) begin
            if (pc_oob) begin
              // The outstanding word (if any) is transferring this cycle.
              Addr_Err <= 1'b1;
              IF_Valid <= 1'b0;
              state    <= S_HALT;
            end else begin
              IF_Inst  <= ROM_Inst;
              IF_PC    <= fetch_pc;
              IF_PC4   <= fetch_pc + 32'd4;
              IF_Valid <= 1'b1;
              fetch_pc <= fetch_pc + 32'd4;
            end
          end
        end

        S_HALT: begin
          if (transfer) IF_Valid <= 1'b0;
          if (Resume) begin
            state <= S_RUN;
            if (Addr_Err) begin
              Addr_Err <= 1'b0;
              fetch_pc <= RESET_PC;
            end
          end
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a behavioural combinational ROM.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        halt_req;
  logic        resume;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  assign rom_inst = rom_fn(rom_addr);

  inst_fetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ROM_Addr   (rom_addr),
    .ROM_Inst   (rom_inst),
    .IF_Valid   (if_valid),
    .ID_Ready   (id_ready),
    .IF_Inst    (if_inst),
    .IF_PC      (if_pc),
    .IF_PC4     (if_pc4),
    .Redir_Valid(redir_valid),
    .Redir_PC   (redir_pc),
    .Halt_Req   (halt_req),
    .Resume     (resume),
    .Addr_Err   (addr_err),
    .Fetch_Cnt  (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last_pc;
    int          inst_bad;
    bit          got_err;

    rst_n = 1'b0; id_ready = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0;
    halt_req = 1'b0; resume = 1'b0;
    #2;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_addr", rom_addr, 32'h0);
    check("rst_pc", if_pc, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Start-up: one WAIT edge, then one capture per edge
    step(); check("wait_valid", 32'(if_valid), 32'd0);
    step();
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_pc", if_pc, 32'h0);
    check("first_pc4", if_pc4, 32'h4);
    check("first_inst", if_inst, rom_fn(32'h0));
    check("first_addr", rom_addr, 32'h4);
    step(); check("pc4", if_pc, 32'h4); check("cnt1", fetch_cnt, 32'd1);
    step(); check("pc8", if_pc, 32'h8); check("cnt2", fetch_cnt, 32'd2);

    // Backpressure holds everything
    id_ready = 1'b0;
    repeat (3) step();
    check("stall_pc", if_pc, 32'h8);
    check("stall_valid", 32'(if_valid), 32'd1);
    check("stall_addr", rom_addr, 32'hC);
    check("stall_cnt", fetch_cnt, 32'd2);
    id_ready = 1'b1;
    step(); check("unstall_pc", if_pc, 32'hC); check("unstall_cnt", fetch_cnt, 32'd3);

    // Misaligned redirect faults and halts
    redir_valid = 1'b1; redir_pc = 32'h6;
    step();
    redir_valid = 1'b0;
    check("bad_redir_err", 32'(addr_err), 32'd1);
    check("bad_redir_valid", 32'(if_valid), 32'd0);
    check("bad_redir_addr", rom_addr, 32'h10);
    check("bad_redir_cnt", fetch_cnt, 32'd4);
    step(); check("halt_still_invalid", 32'(if_valid), 32'd0);
    redir_valid = 1'b1; redir_pc = 32'h20;
    step();
    redir_valid = 1'b0;
    check("halt_ignores_redir", rom_addr, 32'h10);
    check("halt_ignores_redir_v", 32'(if_valid), 32'd0);

    // Resume beats Halt_Req and restarts from RESET_PC
    resume = 1'b1; halt_req = 1'b1;
    step();
    resume = 1'b0; halt_req = 1'b0;
    check("resume_err_clr", 32'(addr_err), 32'd0);
    check("resume_addr", rom_addr, 32'h0);
    step(); check("restart_pc", if_pc, 32'h0); check("restart_valid", 32'(if_valid), 32'd1);
    step(); check("restart_pc4", if_pc, 32'h4); check("restart_cnt", fetch_cnt, 32'd5);

    // Good redirect with simultaneous transfer
    redir_valid = 1'b1; redir_pc = 32'h10;
    step();
    redir_valid = 1'b0;
    check("redir_flush", 32'(if_valid), 32'd0);
    check("redir_cnt", fetch_cnt, 32'd6);
    check("redir_addr", rom_addr, 32'h10);
    step();
    check("redir_valid", 32'(if_valid), 32'd1);
    check("redir_pc", if_pc, 32'h10);
    check("redir_inst", if_inst, rom_fn(32'h10));
    step(); check("redir_next", if_pc, 32'h14); check("redir_next_cnt", fetch_cnt, 32'd7);

    // Halt with a pending word: it stays until transferred
    id_ready = 1'b0; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_pending_v", 32'(if_valid), 32'd1);
    check("halt_pending_pc", if_pc, 32'h14);
    check("halt_addr", rom_addr, 32'h18);
    id_ready = 1'b1;
    step();
    check("halt_drain_v", 32'(if_valid), 32'd0);
    check("halt_drain_cnt", fetch_cnt, 32'd8);
    step(); check("halt_no_fetch", 32'(if_valid), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_keep_addr", rom_addr, 32'h18);
    step(); check("resume_pc", if_pc, 32'h18); check("resume_cnt", fetch_cnt, 32'd8);

    // Asynchronous reset mid-operation, with a redirect pending
    redir_valid = 1'b1; redir_pc = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_cnt", fetch_cnt, 32'd0);
    check("async_addr", rom_addr, 32'h0);
    redir_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(); check("rst2_wait", 32'(if_valid), 32'd0);
    step(); check("rst2_pc", if_pc, 32'h0); check("rst2_valid", 32'(if_valid), 32'd1);

    // Sequential run off the end of the ROM
    last_pc = 32'h0; inst_bad = 0; got_err = 1'b0;
    for (int i = 0; i < 300 && !got_err; i++) begin
      if (if_valid) begin
        last_pc = if_pc;
        if (if_inst !== rom_fn(if_pc)) inst_bad++;
      end
      step();
      got_err = addr_err;
    end
    check("end_err", 32'(got_err), 32'd1);
    check("end_last_pc", last_pc, 32'h3FC);
    check("end_inst_ok", 32'(inst_bad), 32'd0);
    check("end_cnt", fetch_cnt, 32'd256);
    check("end_valid", 32'(if_valid), 32'd0);
    repeat (3) step();
    check("end_no_more", 32'(if_valid), 32'd0);
    check("end_addr", rom_addr, 32'h400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 256, meaning the number of 32-bit words in the instruction ROM; the valid byte range is 0 .. ROM_WORDS*4-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port ROM_Addr, output, 32 bits, byte address driven to the combinational instruction ROM.
REQ-006 SHALL have port ROM_Inst, input, 32 bits, ROM data for ROM_Addr, valid in the same cycle.
REQ-007 SHALL have port IF_Valid, output, 1 bit, fetched instruction available to decode.
REQ-008 SHALL have port ID_Ready, input, 1 bit, decode accepts; a transfer occurs when IF_Valid and ID_Ready are both 1.
REQ-009 SHALL have port IF_Inst, output, 32 bits, fetched instruction.
REQ-010 SHALL have port IF_PC, output, 32 bits, address of IF_Inst.
REQ-011 SHALL have port IF_PC4, output, 32 bits, IF_PC+4.
REQ-012 SHALL have port Redir_Valid, input, 1 bit, branch/jump redirect request.
REQ-013 SHALL have port Redir_PC, input, 32 bits, redirect target.
REQ-014 SHALL have port Halt_Req, input, 1 bit, request to stop fetching.
REQ-015 SHALL have port Resume, input, 1 bit, leave HALT.
REQ-016 SHALL have port Addr_Err, output, 1 bit, sticky fetch-address fault.
REQ-017 SHALL have port Fetch_Cnt, output, 32 bits, count of completed transfers.

Function
REQ-018 SHALL implement states WAIT, RUN and HALT, held in a state register.
REQ-019 WAIT SHALL last exactly one cycle after rst_n deasserts, then go to RUN; no fetch is captured in WAIT.
REQ-020 SHALL hold a 32-bit FetchPC register; ROM_Addr SHALL equal FetchPC combinationally in every state.
REQ-021 In RUN, when IF_Valid=0 or ID_Ready=1, and no redirect, halt or fault applies, the block SHALL capture the following on the next edge: ROM_Inst into IF_Inst, FetchPC into IF_PC, FetchPC+4 into IF_PC4; set IF_Valid=1; and set FetchPC to FetchPC+4. This gives one-cycle latency from address to IF_Valid.
REQ-022 When IF_Valid=1 and ID_Ready=0, IF_Inst, IF_PC, IF_PC4 and FetchPC SHALL hold unchanged.
REQ-023 Sustained throughput SHALL be one instruction per cycle while ID_Ready=1.
REQ-024 Redir_Valid=1 SHALL have highest priority in RUN, ahead of halt and normal fetch. On the next edge it SHALL:
- load FetchPC=Redir_PC;
- force IF_Valid=0 (flush), regardless of ID_Ready.
REQ-025 The first instruction from a redirect target SHALL appear with IF_Valid=1 two edges after Redir_Valid is sampled.
REQ-026 A redirect with Redir_PC[1:0]!=0 or Redir_PC>=ROM_WORDS*4 SHALL, on the next edge, set Addr_Err=1, clear IF_Valid, leave FetchPC unchanged and enter HALT.
REQ-027 If FetchPC>=ROM_WORDS*4 when a capture would occur, the block SHALL not capture; instead it SHALL set Addr_Err=1 and enter HALT, and the current IF_Valid output is still allowed to transfer.
REQ-028 Halt_Req=1 in RUN with no redirect SHALL enter HALT on the next edge with no new capture; a pending IF_Valid SHALL remain until transferred.
REQ-029 In HALT, FetchPC SHALL not change and no capture SHALL occur; Redir_Valid SHALL be ignored.
REQ-030 Resume=1 in HALT SHALL return to RUN on the next edge and clear Addr_Err; when Resume and Halt_Req are both 1, Resume wins.
REQ-031 When Addr_Err is cleared by Resume after a fault, FetchPC SHALL be reset to RESET_PC.
REQ-032 Fetch_Cnt SHALL increment by 1 on each transfer and wrap from 32'hFFFFFFFF to 0.
REQ-033 When a transfer and a redirect occur in the same cycle, the transfer SHALL be counted and the captured word SHALL be flushed.

Reset
REQ-034 rst_n=0 SHALL asynchronously set the outputs and state as follows:
- state=WAIT;
- FetchPC=RESET_PC;
- IF_Valid=0, IF_Inst=0, IF_PC=0, IF_PC4=0;
- Addr_Err=0, Fetch_Cnt=0.
REQ-035 Reset asserted mid-operation SHALL discard any pending instruction and any redirect with no residual effect.

Verification
REQ-036 Release reset, ID_Ready=1 -> IF_Valid rises 2 edges after release with IF_PC=0, IF_PC4=4; the next captures have IF_PC=4, 8, 12 on consecutive cycles.
REQ-037 Hold ID_Ready=0 for 3 cycles while IF_PC=8 -> IF_PC stays 8, FetchPC stays 12 and Fetch_Cnt is unchanged; on release, IF_PC=12 arrives the next cycle.
REQ-038 Redir_Valid=1 with Redir_PC=32'h10 while IF_PC=4 -> next cycle IF_Valid=0; the following cycle IF_Valid=1 with IF_PC=0x10 and IF_Inst=ROM word 4.
REQ-039 Redir_PC=32'h06 -> Addr_Err=1 and state HALT; a later Resume=1 -> Addr_Err=0 and fetch restarts at IF_PC=RESET_PC.
REQ-040 Run sequentially to FetchPC=0x400 with ROM_WORDS=256 -> the last transfer is IF_PC=0x3FC, then Addr_Err=1 with no further IF_Valid.
REQ-041 Pulse rst_n low while IF_Valid=1 and Fetch_Cnt=5 -> IF_Valid=0 and Fetch_Cnt=0 immediately, without waiting for a clock edge.
